dmem_bytelane: RTL and testbench

//  Parametrised data memory for the single-cycle/multicycle CPU data path.
//  - Byte/half/word loads and stores with byte enables.
//  - Sign/zero-extended loads.
//  - Valid/ready request handshake with a registered read response.
//  - Hardware clear FSM after reset; replaces the bulk loop clear.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_load_extend.sv | 34 +++
 rtl/dmem_bytelane.sv | 163 ++++++++++++++++
 tb/tb_dmem_bytelane.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, clear FSM states, lane enables.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Byte enables for an access; half drops a[0], word drops a[1:0], size 11 acts as word.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Selects the addressed byte/half of a raw memory word and sign- or zero-extends it.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_c_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c   = 8'h00;
        half_c   = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        data_c_o = word_i;
        case (addr_lo_i)
            2'd0:    byte_c = word_i[7:0];
            2'd1:    byte_c = word_i[15:8];
            2'd2:    byte_c = word_i[23:16];
            default: byte_c = word_i[31:24];
        endcase
        case (size_i)
            SZ_B:    data_c_o = unsigned_i ? {24'h000000, byte_c}
                                           : {{24{byte_c[7]}}, byte_c};
            SZ_H:    data_c_o = unsigned_i ? {16'h0000, half_c}
                                           : {{16{half_c[15]}}, half_c};
            default: data_c_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with valid/ready requests, registered load response and a clear FSM.
// Optional DMEM_MISALIGN_EXC_EN adds rsp_err and rejects misaligned half/word accesses.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata
`ifdef DMEM_MISALIGN_EXC_EN
    ,
    output logic              rsp_err
`endif
);

    localparam int unsigned     IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    logic [31:0]      mem_q [DEPTH_WORDS];
    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;

    logic [IDX_W-1:0] req_idx;
    logic [1:0]       a_lo;
    logic [31:0]      wdata_rep;
    logic [31:0]      load_c;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;

    assign req_idx = req_addr[IDX_W+1:2];
    assign a_lo    = req_addr[1:0];

    // Address bits above the array span only alias, they never select storage.
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
    end

    always_comb begin
        case (req_size)
            SZ_B:    wdata_rep = {4{req_wdata[7:0]}};
            SZ_H:    wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    dmem_load_extend u_ext (
        .word_i     (mem_q[req_idx]),
        .addr_lo_i  (a_lo),
        .size_i     (req_size),
        .unsigned_i (req_unsigned),
        .data_c_o   (load_c)
    );

`ifdef DMEM_MISALIGN_EXC_EN
    logic rsp_err_q, rsp_err_d;
    logic misaligned;
    assign misaligned = ((req_size == SZ_H) && a_lo[0]) ||
                        (req_size[1] && (a_lo != 2'b00));
    assign rsp_err    = rsp_err_q;
`endif

    // Next state, memory write port and response.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        mem_we      = 1'b0;
        mem_idx     = req_idx;
        mem_be      = 4'h0;
        mem_wdata   = 32'h0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef DMEM_MISALIGN_EXC_EN
        rsp_err_d   = 1'b0;
`endif
        case (state_q)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_we    = 1'b1;
                    mem_idx   = clr_idx_q;
                    mem_be    = 4'hF;
                    clr_idx_d = clr_idx_q + IDX_W'(1);
                    if (clr_idx_q == LAST_IDX) begin
                        state_d = ST_READY;
                    end
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (req_valid) begin
`ifdef DMEM_MISALIGN_EXC_EN
                    if (misaligned) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else
`endif
                    if (req_we) begin
                        mem_we    = 1'b1;
                        mem_be    = lane_be(req_size, a_lo);
                        mem_wdata = wdata_rep;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = load_c;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
`ifdef DMEM_MISALIGN_EXC_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_MISALIGN_EXC_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Storage has no reset; the clear FSM zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == ST_READY);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane (DEPTH_WORDS=16) against a byte-addressed reference memory.
module tb_dmem_bytelane;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned MB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
`ifdef DMEM_MISALIGN_EXC_EN
    logic        rsp_err;
`endif

    always #5 clk = ~clk;

    dmem_bytelane #(
        .DEPTH_WORDS    (DEPTH),
        .ADDR_W         (32),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata)
`ifdef DMEM_MISALIGN_EXC_EN
        ,
        .rsp_err      (rsp_err)
`endif
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata = 32'h0;
    logic [7:0]  mdl [MB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mdl_clear();
        for (int i = 0; i < int'(MB); i++) mdl[i] = 8'h00;
    endfunction

    function automatic bit misal(input logic [31:0] addr, input logic [1:0] sz);
        return (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
    endfunction

    // Stores write little-endian bytes at the size-aligned base, modulo the memory size.
    function automatic void mdl_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] w);
        logic [5:0] a;
        logic [5:0] b;
        a = 6'(addr % MB);
        if (sz == 2'b00) begin
            mdl[a] = w[7:0];
        end else if (sz == 2'b01) begin
            b = a & 6'h3E;
            mdl[b]        = w[7:0];
            mdl[b + 6'd1] = w[15:8];
        end else begin
            b = a & 6'h3C;
            for (int i = 0; i < 4; i++) mdl[b + 6'(i)] = w[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
        logic [5:0] a;
        logic [5:0] b;
        int         val;
        a = 6'(addr % MB);
        if (sz == 2'b00) begin
            val = int'(mdl[a]);
            if (!uns && val >= 128) val -= 256;
            return 32'(val);
        end else if (sz == 2'b01) begin
            b   = a & 6'h3E;
            val = int'(mdl[b]) + 256 * int'(mdl[b + 6'd1]);
            if (!uns && val >= 32768) val -= 65536;
            return 32'(val);
        end
        b = a & 6'h3C;
        return {mdl[b + 6'd3], mdl[b + 6'd2], mdl[b + 6'd1], mdl[b]};
    endfunction

    // Monitor: every response pops one expectation; idle cycles must hold the last data.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
`ifdef DMEM_MISALIGN_EXC_EN
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
`endif
                    last_rdata = mon_e.rdata;
                end
            end else begin
                chk("rsp_hold", rsp_rdata, last_rdata);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        wait_ready();
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
`ifdef DMEM_MISALIGN_EXC_EN
        if (misal(addr, sz)) begin
            e.rdata = 32'h0;
            e.err   = 1'b1;
            exp_q.push_back(e);
        end else
`endif
        if (we) begin
            mdl_store(addr, sz, wd);
        end else begin
            e.rdata = mdl_load(addr, sz, uns);
            e.err   = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic measure_clear(output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (req_ready) break;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mdl_clear();

        // Reset state and clear latency
        @(posedge clk);
        #1;
        chk("reset_ready", {31'b0, req_ready}, 32'd0);
        chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        reset = 1'b0;
        measure_clear(cyc);
        chk("clear_latency", 32'(cyc), 32'(DEPTH));
        do_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);

        // Mixed-width stores merged into one word
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007A);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // Sign and zero extension
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h000080F0);
        do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);

        // Aliasing beyond the array span
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
        do_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);

        // Store followed immediately by a load of the same word
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h13579BDF);
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);

        // Misaligned accesses
        do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h00005555);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
        do_req(1'b0, 2'b11, 1'b1, 32'h0B, 32'h0);
        idle(2);

        // Reset coinciding with a load: no response, clear restarts
        wait_ready();
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_addr     = 32'h08;
        reset        = 1'b1;
        exp_q.delete();
        last_rdata   = 32'h0;
        mdl_clear();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        chk("drop_valid", {31'b0, rsp_valid}, 32'd0);
        chk("drop_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("drop_valid_later", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        measure_clear(cyc);
        chk("clear_restart_latency", 32'(cyc), 32'(DEPTH));
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // Random traffic against the reference memory
        for (int i = 0; i < 400; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
